pwm_ramp_ctrl: RTL and testbench
================================

Name: pwm_ramp_ctrl

Overview:
- Soft-start / slew-rate controller that sequences the duty word driven into the pwm block's Data_in.
- Accepts a target duty through a valid/ready command handshake.
- Moves its duty_out toward the target by at most STEP counts every TICK_DIV clock cycles, so the motor/LED load never sees a duty jump larger than STEP.
- Sits between the register/command logic and pwm, in the same clk domain.

Parameters:
- PWM_Width, 8, width of duty words; must match the pwm instance.
- STEP, 1, maximum duty change per tick; legal range 1..2^PWM_Width-1.
- TICK_DIV, 256, clk cycles per ramp step; legal range >= 1; tick counter width = clog2(TICK_DIV), minimum 1 bit.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset (asserted at 0).
- cmd_valid  in  1  new target offered.
- cmd_ready  out  1  controller can accept a target.
- cmd_duty  in  PWM_Width  target duty; sampled only on handshake.
- duty_out  out  PWM_Width  duty word to pwm Data_in; registered.
- busy  out  1  ramp in progress.
- done  out  1  one-cycle pulse: target reached.

Behaviour:
- Reset (rst=0, async): duty_out=0, target=0, state IDLE, tick=0, cmd_ready=1, busy=0, done=0. A reset mid-ramp drops duty_out to 0 immediately, with no done pulse.
- States:
  - IDLE: cmd_ready=1, busy=0.
  - RAMP_UP / RAMP_DOWN: cmd_ready=0, busy=1.
- Handshake: accept occurs on a rising edge with cmd_valid=1 and cmd_ready=1. On that edge cmd_duty is latched into target and tick is cleared to 0.
  - cmd_duty > duty_out: go to RAMP_UP.
  - cmd_duty < duty_out: go to RAMP_DOWN.
  - cmd_duty == duty_out: stay IDLE and pulse done in the following cycle.
- While cmd_ready=0, cmd_valid is ignored and no command is queued.
- Tick: in RAMP states, tick increments each clk and wraps from TICK_DIV-1 to 0. A step is performed on the edge where tick == TICK_DIV-1.
  - The first step lands TICK_DIV edges after the accept edge; each later step lands TICK_DIV edges after the previous one.
  - With TICK_DIV=1, a step occurs on every edge.
- Step arithmetic, done in PWM_Width bits with no wrap-around:
  - RAMP_UP: if (target - duty_out) <= STEP then duty_out = target, else duty_out = duty_out + STEP.
  - RAMP_DOWN: if (duty_out - target) <= STEP then duty_out = target, else duty_out = duty_out - STEP.
  - The subtraction is always non-negative by construction, so duty_out never overshoots, wraps past 2^PWM_Width-1, or drops below 0.
- Completion: on the step edge that makes duty_out == target, the state returns to IDLE.
  - busy=0, cmd_ready=1 and done=1 in the same cycle that duty_out first equals target.
  - done is high for exactly one cycle.
  - A new command may be accepted in that same cycle.
- Latency: for delta D = |target - duty_out|, there are ceil(D/STEP) steps, and done occurs ceil(D/STEP)*TICK_DIV edges after the accept edge.
- Outputs are glitch-free registers. duty_out changes only on step edges or reset.

Optional Feature:
- Macro: PWM_RAMP_KILL_EN.
- Defined: adds input port kill (1 bit, active-high, synchronous).
  - When kill=1 at an edge: duty_out=0, target=0, tick=0, state IDLE, busy=0, no done pulse.
  - kill overrides any handshake at that edge.
  - cmd_ready=0 while kill=1.
- Not defined: no kill port; the block's behaviour is exactly as above.

Test Plan:
All scenarios use PWM_Width=8, STEP=16, TICK_DIV=4.
- Reset: hold rst=0, then release -> duty_out=0, cmd_ready=1, busy=0, done=0. Assert rst=0 asynchronously mid-cycle -> outputs clear without waiting for clk.
- Ramp up 0->64 -> duty_out becomes 16/32/48/64 at edges 4/8/12/16 after accept; busy=1 throughout; done=1 only in the cycle duty_out first reads 64; cmd_ready returns to 1 in that cycle.
- Partial step: 64->100 -> 80, 96, 100. Then 100->10 -> 84, 68, 52, 36, 20, 10. No overshoot; done after 6*4=24 edges.
- Boundary: 250->255 -> a single step to 255 with no wrap. 255->255 -> done pulses in the cycle after accept; busy stays 0.
- Command during ramp: offer cmd_valid=1 with cmd_duty=0 while ramping 0->64 -> ignored (cmd_ready=0); the ramp completes at 64.
- Mid-ramp abort: assert rst=0 while duty_out=32 -> duty_out=0 immediately, no done. With PWM_RAMP_KILL_EN, kill=1 -> duty_out=0 at the next edge, busy=0, no done.

Source files
------------

// File: rtl/pwm_ramp_ctrl.sv
// Slew-rate limited duty sequencer feeding the pwm Data_in word.
// Optional synchronous kill input enabled by defining PWM_RAMP_KILL_EN.
module pwm_ramp_ctrl #(
  parameter int PWM_Width = 8,
  parameter int STEP      = 1,
  parameter int TICK_DIV  = 256
) (
  input  logic                 clk,
  input  logic                 rst,
`ifdef PWM_RAMP_KILL_EN
  input  logic                 kill,
`endif
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [PWM_Width-1:0] cmd_duty,
  output logic [PWM_Width-1:0] duty_out,
  output logic                 busy,
  output logic                 done
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0]        TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [PWM_Width-1:0] STEP_W    = PWM_Width'(STEP);

  typedef enum logic [1:0] {
    IDLE,
    RAMP_UP,
    RAMP_DOWN
  } state_t;

  state_t               state, state_nxt;
  logic [PWM_Width-1:0] target, target_nxt;
  logic [PWM_Width-1:0] duty_nxt;
  logic [PWM_Width-1:0] diff;
  logic [TW-1:0]        tick, tick_nxt;
  logic                 done_nxt;
  logic                 kill_act;
  logic                 accept;
  logic                 step;

`ifdef PWM_RAMP_KILL_EN
  assign kill_act = kill;
`else
  assign kill_act = 1'b0;
`endif

  assign cmd_ready = (state == IDLE) && !kill_act;
  assign busy      = (state != IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign step      = (tick == TICK_LAST);

  always_comb begin
    state_nxt  = state;
    target_nxt = target;
    duty_nxt   = duty_out;
    tick_nxt   = tick;
    done_nxt   = 1'b0;
    diff       = '0;
    if (kill_act) begin
      state_nxt  = IDLE;
      target_nxt = '0;
      duty_nxt   = '0;
      tick_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            target_nxt = cmd_duty;
            tick_nxt   = '0;
            if (cmd_duty > duty_out)      state_nxt = RAMP_UP;
            else if (cmd_duty < duty_out) state_nxt = RAMP_DOWN;
            else                          done_nxt  = 1'b1;
          end
        end
        RAMP_UP: begin
          diff     = target - duty_out;
          tick_nxt = step ? '0 : tick + 1'b1;
          if (step) begin
            // Clamping on the remaining distance keeps the sum from wrapping.
            if (diff <= STEP_W) begin
              duty_nxt  = target;
              state_nxt = IDLE;
              done_nxt  = 1'b1;
            end else begin
              duty_nxt = duty_out + STEP_W;
            end
          end
        end
        RAMP_DOWN: begin
          diff     = duty_out - target;
          tick_nxt = step ? '0 : tick + 1'b1;
          if (step) begin
            if (diff <= STEP_W) begin
              duty_nxt  = target;
              state_nxt = IDLE;
              done_nxt  = 1'b1;
            end else begin
              duty_nxt = duty_out - STEP_W;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      target   <= '0;
      duty_out <= '0;
      tick     <= '0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      target   <= target_nxt;
      duty_out <= duty_nxt;
      tick     <= tick_nxt;
      done     <= done_nxt;
    end
  end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed bench for pwm_ramp_ctrl with PWM_Width=8, STEP=16, TICK_DIV=4.
module tb_pwm_ramp_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [7:0] cmd_duty = 8'd0;
  logic       cmd_ready, busy, done;
  logic [7:0] duty_out;
`ifdef PWM_RAMP_KILL_EN
  logic       kill = 1'b0;
`endif
  int n_checks = 0;
  int n_fail = 0;

  pwm_ramp_ctrl #(.PWM_Width(8), .STEP(16), .TICK_DIV(4)) dut (
    .clk(clk),
    .rst(rst),
`ifdef PWM_RAMP_KILL_EN
    .kill(kill),
`endif
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_duty(cmd_duty),
    .duty_out(duty_out),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick(); tick(); tick();
    n_checks++;
    if (duty_out !== 8'd0 || cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_held: duty=%0d ready=%b busy=%b done=%b expected duty=0 ready=1 busy=0 done=0",
               duty_out, cmd_ready, busy, done);
    end
    rst = 1'b1;
    tick();
    n_checks++;
    if (duty_out !== 8'd0 || cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: duty=%0d ready=%b busy=%b done=%b expected duty=0 ready=1 busy=0 done=0",
               duty_out, cmd_ready, busy, done);
    end
  endtask

  task automatic test_ramp_up();
    int exp_steps[4] = '{16, 32, 48, 64};
    logic [7:0] exp_duty;
    logic last;
    cmd_duty = 8'd64; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    exp_duty = 8'd0;
    for (int s = 0; s < 4; s++) begin
      for (int e = 1; e <= 4; e++) begin
        tick();
        if (e == 4) exp_duty = 8'(exp_steps[s]);
        last = (s == 3) && (e == 4);
        n_checks++;
        if (duty_out !== exp_duty || busy !== !last || done !== last || cmd_ready !== last) begin
          n_fail++;
          $display("FAIL ramp_up s%0d e%0d: duty=%0d busy=%b done=%b ready=%b expected duty=%0d busy=%b done=%b ready=%b",
                   s, e, duty_out, busy, done, cmd_ready, exp_duty, !last, last, last);
        end
      end
    end
    tick();
    n_checks++;
    if (done !== 1'b0 || duty_out !== 8'd64 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ramp_up_after: done=%b duty=%0d busy=%b expected done=0 duty=64 busy=0", done, duty_out, busy);
    end
  endtask

  task automatic test_partial_step();
    int up_steps[3] = '{80, 96, 100};
    int dn_steps[6] = '{84, 68, 52, 36, 20, 10};
    logic [7:0] exp_duty;
    logic last;
    cmd_duty = 8'd100; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    exp_duty = 8'd64;
    for (int s = 0; s < 3; s++) begin
      for (int e = 1; e <= 4; e++) begin
        tick();
        if (e == 4) exp_duty = 8'(up_steps[s]);
        last = (s == 2) && (e == 4);
        n_checks++;
        if (duty_out !== exp_duty || busy !== !last || done !== last) begin
          n_fail++;
          $display("FAIL partial_up s%0d e%0d: duty=%0d busy=%b done=%b expected duty=%0d busy=%b done=%b",
                   s, e, duty_out, busy, done, exp_duty, !last, last);
        end
      end
    end
    // Command offered in the done cycle is accepted on the next edge.
    cmd_duty = 8'd10; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    for (int s = 0; s < 6; s++) begin
      for (int e = 1; e <= 4; e++) begin
        tick();
        if (e == 4) exp_duty = 8'(dn_steps[s]);
        last = (s == 5) && (e == 4);
        n_checks++;
        if (duty_out !== exp_duty || busy !== !last || done !== last || cmd_ready !== last) begin
          n_fail++;
          $display("FAIL partial_down s%0d e%0d: duty=%0d busy=%b done=%b ready=%b expected duty=%0d busy=%b done=%b ready=%b",
                   s, e, duty_out, busy, done, cmd_ready, exp_duty, !last, last, last);
        end
      end
    end
  endtask

  task automatic test_boundary();
    int edges;
    logic seen;
    cmd_duty = 8'd250; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    edges = 0; seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      tick();
      edges++;
      if (done === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (!seen || edges != 60 || duty_out !== 8'd250) begin
      n_fail++;
      $display("FAIL ramp_to_250: seen=%b edges=%0d duty=%0d expected seen=1 edges=60 duty=250", seen, edges, duty_out);
    end
    cmd_duty = 8'd255; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      tick();
      n_checks++;
      if (duty_out !== ((e == 4) ? 8'd255 : 8'd250) || done !== (e == 4)) begin
        n_fail++;
        $display("FAIL top_step e%0d: duty=%0d done=%b expected duty=%0d done=%b",
                 e, duty_out, done, (e == 4) ? 255 : 250, (e == 4));
      end
    end
    tick();
    cmd_duty = 8'd255; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0 || duty_out !== 8'd255 || cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL equal_cmd: done=%b busy=%b duty=%0d ready=%b expected done=1 busy=0 duty=255 ready=1",
               done, busy, duty_out, cmd_ready);
    end
    tick();
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0 || duty_out !== 8'd255) begin
      n_fail++;
      $display("FAIL equal_cmd_after: done=%b busy=%b duty=%0d expected done=0 busy=0 duty=255", done, busy, duty_out);
    end
  endtask

  task automatic test_cmd_during_ramp();
    logic [7:0] exp_duty;
    logic last;
    rst = 1'b0; tick(); rst = 1'b1; tick();
    cmd_duty = 8'd64; cmd_valid = 1'b1;
    tick();
    cmd_duty = 8'd0;
    exp_duty = 8'd0;
    for (int e = 1; e <= 16; e++) begin
      tick();
      if (e % 4 == 0) exp_duty = 8'(e * 4);
      last = (e == 16);
      n_checks++;
      if (duty_out !== exp_duty || cmd_ready !== last || busy !== !last) begin
        n_fail++;
        $display("FAIL cmd_ignored e%0d: duty=%0d ready=%b busy=%b expected duty=%0d ready=%b busy=%b",
                 e, duty_out, cmd_ready, busy, exp_duty, last, !last);
      end
    end
    cmd_valid = 1'b0;
    tick();
    n_checks++;
    if (duty_out !== 8'd64 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL cmd_ignored_end: duty=%0d busy=%b done=%b expected duty=64 busy=0 done=0", duty_out, busy, done);
    end
  endtask

  task automatic test_abort();
    logic saw_done;
    rst = 1'b0; tick(); rst = 1'b1; tick();
    cmd_duty = 8'd64; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    for (int e = 0; e < 8; e++) tick();
    n_checks++;
    if (duty_out !== 8'd32 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_pre: duty=%0d busy=%b expected duty=32 busy=1", duty_out, busy);
    end
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (duty_out !== 8'd0 || busy !== 1'b0 || cmd_ready !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: duty=%0d busy=%b ready=%b done=%b expected duty=0 busy=0 ready=1 done=0",
               duty_out, busy, cmd_ready, done);
    end
    saw_done = 1'b0;
    tick(); if (done !== 1'b0) saw_done = 1'b1;
    rst = 1'b1;
    for (int e = 0; e < 6; e++) begin
      tick();
      if (done !== 1'b0) saw_done = 1'b1;
    end
    n_checks++;
    if (saw_done || duty_out !== 8'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_after: saw_done=%b duty=%0d busy=%b expected saw_done=0 duty=0 busy=0",
               saw_done, duty_out, busy);
    end
  endtask

`ifdef PWM_RAMP_KILL_EN
  task automatic test_kill();
    cmd_duty = 8'd64; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    for (int e = 0; e < 8; e++) tick();
    kill = 1'b1;
    #1;
    n_checks++;
    if (cmd_ready !== 1'b0 || duty_out !== 8'd32) begin
      n_fail++;
      $display("FAIL kill_pre: ready=%b duty=%0d expected ready=0 duty=32", cmd_ready, duty_out);
    end
    tick();
    kill = 1'b0;
    n_checks++;
    if (duty_out !== 8'd0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL kill: duty=%0d busy=%b done=%b expected duty=0 busy=0 done=0", duty_out, busy, done);
    end
    tick();
    n_checks++;
    if (done !== 1'b0 || cmd_ready !== 1'b1 || duty_out !== 8'd0) begin
      n_fail++;
      $display("FAIL kill_after: done=%b ready=%b duty=%0d expected done=0 ready=1 duty=0", done, cmd_ready, duty_out);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_ramp_up();
    test_partial_step();
    test_boundary();
    test_cmd_during_ramp();
    test_abort();
`ifdef PWM_RAMP_KILL_EN
    test_kill();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
